// File: rtl/stream_priority_encoder.sv
// stream_priority_encoder
//   Pipelined first-set-bit encoder with a valid/ready input and a one-entry
//   registered output stage. It supports fixed LSB-first priority (ROTATE=0)
//   or a round-robin search (ROTATE=1) that starts at an internal pointer.
//   The pointer advances past the last selected bit.
//
// Parameters
//   WIDTH   request vector width (>= 2, any value)
//   ROTATE  0 = fixed priority, bit 0 highest; 1 = rotating start
//   PW      index width, $clog2(WIDTH) (local)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_req is valid this cycle
//   in_ready   block can accept in_req this cycle
//   in_req     request vector
//   out_valid  result registers hold a valid result
//   out_ready  downstream accepts the result this cycle
//   out_pos    index of the selected bit (0 when nothing is set)
//   out_found  1 if the accepted in_req had any bit set
//   out_onehot one-hot of out_pos, zero when not found (ONEHOT_OUT_EN only)
//
// Build option
//   ONEHOT_OUT_EN  adds the registered out_onehot port
module stream_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int ROTATE = 0,
  localparam int PW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_pos,
  output logic             out_found
`ifdef ONEHOT_OUT_EN
  ,
  output logic [WIDTH-1:0] out_onehot
`endif
);

  logic          accept;
  logic [PW-1:0] ptr;
  logic [PW-1:0] enc_pos;
  logic          enc_found;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan from ptr with explicit modulo-WIDTH wrap. The loop runs from the
  // farthest offset to the nearest, so the nearest set bit is written last
  // and wins. The sum is one bit wider than an index, so ptr + offset
  // (at most 2*WIDTH-2) cannot overflow before the wrap subtraction.
  // With ROTATE=0, ptr is tied to zero, so this is plain LSB-first priority.
  always_comb begin
    enc_pos   = '0;
    enc_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(WIDTH))
        scan_sum = scan_sum - (PW+1)'(WIDTH);
      scan_idx = scan_sum[PW-1:0];
      if (in_req[scan_idx]) begin
        enc_pos   = scan_idx;
        enc_found = 1'b1;
      end
    end
  end

  generate
    if (ROTATE != 0) begin : g_rotate
      // The pointer moves only when a bit was actually selected.
      // An all-zero request leaves the search origin where it was.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ptr <= '0;
        else if (accept && enc_found)
          ptr <= (enc_pos == PW'(WIDTH - 1)) ? '0 : enc_pos + 1'b1;
      end
    end else begin : g_fixed
      assign ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_found <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pos   <= enc_pos;
      out_found <= enc_found;
    end else if (out_ready) begin
      // Drained with nothing new: data registers keep their last values.
      out_valid <= 1'b0;
    end
  end

`ifdef ONEHOT_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_onehot <= '0;
    else if (accept)
      out_onehot <= enc_found ? (WIDTH'(1) << enc_pos) : '0;
  end
`endif

endmodule

// File: tb/tb_stream_priority_encoder.sv
module tb_stream_priority_encoder;

  typedef struct packed {
    logic       found;
    logic [2:0] pos;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_req;

  logic       in_ready_f8, out_valid_f8, out_found_f8;
  logic [2:0] out_pos_f8;
  logic       in_ready_r8, out_valid_r8, out_found_r8;
  logic [2:0] out_pos_r8;
  logic       in_ready_r5, out_valid_r5, out_found_r5;
  logic [2:0] out_pos_r5;
`ifdef ONEHOT_OUT_EN
  logic [7:0] out_onehot_f8, out_onehot_r8;
  logic [4:0] out_onehot_r5;
`endif

  exp_t qf8[$];
  exp_t qr8[$];
  exp_t qr5[$];
  int   mptr8 = 0;
  int   mptr5 = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  stream_priority_encoder #(.WIDTH(8), .ROTATE(0)) u_f8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f8),
    .in_req(in_req), .out_valid(out_valid_f8), .out_ready(out_ready),
    .out_pos(out_pos_f8), .out_found(out_found_f8)
`ifdef ONEHOT_OUT_EN
    , .out_onehot(out_onehot_f8)
`endif
  );

  stream_priority_encoder #(.WIDTH(8), .ROTATE(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r8),
    .in_req(in_req), .out_valid(out_valid_r8), .out_ready(out_ready),
    .out_pos(out_pos_r8), .out_found(out_found_r8)
`ifdef ONEHOT_OUT_EN
    , .out_onehot(out_onehot_r8)
`endif
  );

  stream_priority_encoder #(.WIDTH(5), .ROTATE(1)) u_r5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r5),
    .in_req(in_req[4:0]), .out_valid(out_valid_r5), .out_ready(out_ready),
    .out_pos(out_pos_r5), .out_found(out_found_r5)
`ifdef ONEHOT_OUT_EN
    , .out_onehot(out_onehot_r5)
`endif
  );

  // Reference: first set bit scanning start, start+1, ... modulo w.
  function automatic exp_t model(input logic [7:0] req, input int w, input int start);
    exp_t e;
    int   i;
    e = '0;
    for (int k = w - 1; k >= 0; k--) begin
      i = (start + k) % w;
      if (req[i[2:0]]) begin
        e.pos   = i[2:0];
        e.found = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic int next_ptr(input exp_t e, input int w, input int p);
    if (!e.found) return p;
    return (int'(e.pos) == w - 1) ? 0 : int'(e.pos) + 1;
  endfunction

  // One cycle: drive at the falling edge, score the output handshake and
  // record expectations for the accept that the next rising edge will take.
  task automatic step(input logic v, input logic [7:0] req, input logic rdy);
    exp_t e;
    logic [7:0] oh;
    in_valid  = v;
    in_req    = req;
    out_ready = rdy;
    #1;
    if (out_valid_f8 && rdy) begin
      total_cnt++;
      if (qf8.size() == 0) $display("FAIL sb_f8: out_valid=1 but no result expected");
      else begin
        e = qf8.pop_front();
        oh = e.found ? (8'd1 << e.pos) : 8'd0;
        if ({out_found_f8, out_pos_f8} !== {e.found, e.pos})
          $display("FAIL sb_f8: got found=%0b pos=%0d, want found=%0b pos=%0d",
                   out_found_f8, out_pos_f8, e.found, e.pos);
`ifdef ONEHOT_OUT_EN
        else if (out_onehot_f8 !== oh)
          $display("FAIL sb_f8_onehot: got %h, want %h", out_onehot_f8, oh);
`endif
        else pass_cnt++;
      end
    end
    if (out_valid_r8 && rdy) begin
      total_cnt++;
      if (qr8.size() == 0) $display("FAIL sb_r8: out_valid=1 but no result expected");
      else begin
        e = qr8.pop_front();
        oh = e.found ? (8'd1 << e.pos) : 8'd0;
        if ({out_found_r8, out_pos_r8} !== {e.found, e.pos})
          $display("FAIL sb_r8: got found=%0b pos=%0d, want found=%0b pos=%0d",
                   out_found_r8, out_pos_r8, e.found, e.pos);
`ifdef ONEHOT_OUT_EN
        else if (out_onehot_r8 !== oh)
          $display("FAIL sb_r8_onehot: got %h, want %h", out_onehot_r8, oh);
`endif
        else pass_cnt++;
      end
    end
    if (out_valid_r5 && rdy) begin
      total_cnt++;
      if (qr5.size() == 0) $display("FAIL sb_r5: out_valid=1 but no result expected");
      else begin
        e = qr5.pop_front();
        oh = e.found ? (8'd1 << e.pos) : 8'd0;
        if ({out_found_r5, out_pos_r5} !== {e.found, e.pos})
          $display("FAIL sb_r5: got found=%0b pos=%0d, want found=%0b pos=%0d",
                   out_found_r5, out_pos_r5, e.found, e.pos);
`ifdef ONEHOT_OUT_EN
        else if (out_onehot_r5 !== oh[4:0])
          $display("FAIL sb_r5_onehot: got %h, want %h", out_onehot_r5, oh[4:0]);
`endif
        else pass_cnt++;
      end
    end
    if (v && in_ready_f8) qf8.push_back(model(req, 8, 0));
    if (v && in_ready_r8) begin
      e = model(req, 8, mptr8);
      qr8.push_back(e);
      mptr8 = next_ptr(e, 8, mptr8);
    end
    if (v && in_ready_r5) begin
      e = model({3'b000, req[4:0]}, 5, mptr5);
      qr5.push_back(e);
      mptr5 = next_ptr(e, 5, mptr5);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model;
    qf8.delete();
    qr8.delete();
    qr5.delete();
    mptr8 = 0;
    mptr5 = 0;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    in_req    = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    in_req    = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid_f8, out_pos_f8, out_found_f8} !== 5'b0)
      $display("FAIL reset_f8: got valid=%0b pos=%0d found=%0b, want 0/0/0",
               out_valid_f8, out_pos_f8, out_found_f8);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid_r5, out_pos_r5, out_found_r5} !== 5'b0)
      $display("FAIL reset_r5: got valid=%0b pos=%0d found=%0b, want 0/0/0",
               out_valid_r5, out_pos_r5, out_found_r5);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready_f8, in_ready_r8, in_ready_r5} !== 3'b111)
      $display("FAIL reset_in_ready: got %b, want 111", {in_ready_f8, in_ready_r8, in_ready_r5});
    else pass_cnt++;
`ifdef ONEHOT_OUT_EN
    total_cnt++;
    if (out_onehot_f8 !== 8'h00)
      $display("FAIL reset_onehot: got %h, want 00", out_onehot_f8);
    else pass_cnt++;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_fixed;
    step(1'b1, 8'b0010_1000, 1'b1);
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b1, 1'b1, 3'd3})
      $display("FAIL fixed_28: got valid=%0b found=%0b pos=%0d, want 1/1/3",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
`ifdef ONEHOT_OUT_EN
    total_cnt++;
    if (out_onehot_f8 !== 8'h08)
      $display("FAIL fixed_onehot: got %h, want 08", out_onehot_f8);
    else pass_cnt++;
`endif
    step(1'b1, 8'h00, 1'b1);
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL fixed_00: got valid=%0b found=%0b pos=%0d, want 1/0/0",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
    step(1'b1, 8'h80, 1'b1);
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b1, 1'b1, 3'd7})
      $display("FAIL fixed_80: got valid=%0b found=%0b pos=%0d, want 1/1/7",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b1);
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b0, 1'b1, 3'd7})
      $display("FAIL fixed_drain: got valid=%0b found=%0b pos=%0d, want 0/1/7",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    step(1'b1, 8'h10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      in_valid  = 1'b1;
      in_req    = 8'h03;
      out_ready = 1'b0;
      #1;
      total_cnt++;
      if (in_ready_f8 !== 1'b0)
        $display("FAIL bp_in_ready[%0d]: got %0b, want 0", c, in_ready_f8);
      else pass_cnt++;
      step(1'b1, 8'h03, 1'b0);
      total_cnt++;
      if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b1, 1'b1, 3'd4})
        $display("FAIL bp_hold[%0d]: got valid=%0b found=%0b pos=%0d, want 1/1/4",
                 c, out_valid_f8, out_found_f8, out_pos_f8);
      else pass_cnt++;
    end
    step(1'b1, 8'h06, 1'b1);
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== {1'b1, 1'b1, 3'd1})
      $display("FAIL bp_release: got valid=%0b found=%0b pos=%0d, want 1/1/1",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_rotate;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'hFF, 1'b1);
      total_cnt++;
      if (out_pos_r8 !== 3'(k))
        $display("FAIL rot_ff[%0d]: got pos=%0d, want %0d", k, out_pos_r8, k);
      else pass_cnt++;
    end
    step(1'b1, 8'h01, 1'b1);
    total_cnt++;
    if ({out_found_r8, out_pos_r8} !== {1'b1, 3'd0})
      $display("FAIL rot_wrap: got found=%0b pos=%0d, want 1/0", out_found_r8, out_pos_r8);
    else pass_cnt++;
    step(1'b1, 8'h00, 1'b1);
    total_cnt++;
    if ({out_valid_r8, out_found_r8, out_pos_r8} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL rot_none: got valid=%0b found=%0b pos=%0d, want 1/0/0",
               out_valid_r8, out_found_r8, out_pos_r8);
    else pass_cnt++;
    step(1'b1, 8'hFF, 1'b1);
    total_cnt++;
    if (out_pos_r8 !== 3'd1)
      $display("FAIL rot_ptr_kept: got pos=%0d, want 1", out_pos_r8);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_rotate_w5;
    do_reset();
    step(1'b1, 8'h10, 1'b1);
    total_cnt++;
    if ({out_found_r5, out_pos_r5} !== {1'b1, 3'd4})
      $display("FAIL w5_top: got found=%0b pos=%0d, want 1/4", out_found_r5, out_pos_r5);
    else pass_cnt++;
    step(1'b1, 8'h11, 1'b1);
    total_cnt++;
    if (out_pos_r5 !== 3'd0)
      $display("FAIL w5_wrap: got pos=%0d, want 0", out_pos_r5);
    else pass_cnt++;
    step(1'b1, 8'h11, 1'b1);
    total_cnt++;
    if (out_pos_r5 !== 3'd4)
      $display("FAIL w5_from1: got pos=%0d, want 4", out_pos_r5);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_async_reset;
    step(1'b1, 8'h24, 1'b1);
    step(1'b1, 8'h24, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid_f8, out_found_f8, out_pos_f8} !== 5'b0)
      $display("FAIL arst_f8: got valid=%0b found=%0b pos=%0d, want 0/0/0",
               out_valid_f8, out_found_f8, out_pos_f8);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid_r8, out_pos_r8} !== 4'b0)
      $display("FAIL arst_r8: got valid=%0b pos=%0d, want 0/0", out_valid_r8, out_pos_r8);
    else pass_cnt++;
    total_cnt++;
    if (in_ready_f8 !== 1'b1)
      $display("FAIL arst_in_ready: got %0b, want 1", in_ready_f8);
    else pass_cnt++;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hFF, 1'b1);
    total_cnt++;
    if (out_pos_r8 !== 3'd0)
      $display("FAIL arst_ptr: got pos=%0d, want 0", out_pos_r8);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] r;
    for (int n = 0; n < 60; n++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (qf8.size() + qr8.size() + qr5.size() != 0)
      $display("FAIL rand_drain: %0d results never delivered, want 0",
               qf8.size() + qr8.size() + qr5.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_rotate();
    test_rotate_w5();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
